// File: rtl/spine_route_arb_stage.sv
// Spine ingress stage: round-robin arbitration over N_IN request streams, {group,leaf} -> spine port
// decode, and a one-deep registered output slot. Requests with an invalid group are dropped and counted.
module spine_route_arb_stage #(
  parameter int GROUP_ID   = 4,
  parameter int NUM_GROUPS = 8,
  parameter int NUM_LEAFS  = 4,
  parameter int GROUP_W    = 4,
  parameter int LEAF_W     = 2,
  parameter int PORT_W     = 4,
  parameter int DATA_W     = 32,
  parameter int N_IN       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_IN-1:0]                  in_valid,
  output logic [N_IN-1:0]                  in_ready,
  input  logic [N_IN*(GROUP_W+LEAF_W)-1:0] in_dest,
  input  logic [N_IN*DATA_W-1:0]           in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PORT_W-1:0]                out_port,
  output logic [$clog2(N_IN)-1:0]          out_src,
  output logic [DATA_W-1:0]                out_data,
  output logic                             route_err,
  output logic [CNT_W-1:0]                 drop_cnt
);

  localparam int DEST_W = GROUP_W + LEAF_W;
  localparam int SRC_W  = $clog2(N_IN);

  logic [SRC_W-1:0]   last_q;
  logic [SRC_W-1:0]   winner;
  logic               any_valid;
  logic [DEST_W-1:0]  win_dest;
  logic [DATA_W-1:0]  win_data;
  logic [GROUP_W-1:0] win_group;
  logic [LEAF_W-1:0]  win_leaf;
  logic               dest_ok;
  logic [PORT_W-1:0]  dest_port;
  logic               load_en;
  logic               accept;

  // Scan starts one past the last granted input so every requester is served within N_IN grants.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 1; k <= N_IN; k++) begin
      if (!any_valid && in_valid[(int'(last_q) + k) % N_IN]) begin
        any_valid = 1'b1;
        winner    = SRC_W'((int'(last_q) + k) % N_IN);
      end
    end
  end

  assign win_dest  = in_dest[winner*DEST_W +: DEST_W];
  assign win_data  = in_data[winner*DATA_W +: DATA_W];
  assign win_group = win_dest[DEST_W-1:LEAF_W];
  assign win_leaf  = win_dest[LEAF_W-1:0];

  // Local leafs occupy ports 1..NUM_LEAFS; remote groups follow, skipping our own group id.
  always_comb begin
    dest_ok   = 1'b0;
    dest_port = '0;
    if (int'(win_group) == GROUP_ID) begin
      dest_ok   = 1'b1;
      dest_port = PORT_W'(int'(win_leaf) + 1);
    end else if (win_group != '0 && int'(win_group) <= NUM_GROUPS) begin
      dest_ok = 1'b1;
      if (int'(win_group) < GROUP_ID)
        dest_port = PORT_W'(NUM_LEAFS + int'(win_group));
      else
        dest_port = PORT_W'(NUM_LEAFS + int'(win_group) - 1);
    end
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both high. The slot can take
  // a new item when empty or being drained this cycle; only the arbitration winner sees ready, and
  // nothing is accepted while reset is asserted.
  assign load_en  = !out_valid || out_ready;
  assign accept   = any_valid && load_en;
  assign in_ready = (accept && rst_n) ? (N_IN'(1) << winner) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= SRC_W'(N_IN - 1);
      out_valid <= 1'b0;
      out_port  <= '0;
      out_src   <= '0;
      out_data  <= '0;
      route_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      route_err <= accept && !dest_ok;
      if (accept) begin
        last_q <= winner;
      end
      if (accept && dest_ok) begin
        out_valid <= 1'b1;
        out_port  <= dest_port;
        out_src   <= winner;
        out_data  <= win_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && !dest_ok && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spine_route_arb_stage.sv
// Directed bench for spine_route_arb_stage: drivers push expected items into a queue, and a negedge
// monitor pops and compares every output transfer.
module tb_spine_route_arb_stage;

  localparam int GROUP_ID   = 4;
  localparam int NUM_GROUPS = 8;
  localparam int NUM_LEAFS  = 4;
  localparam int GROUP_W    = 4;
  localparam int LEAF_W     = 2;
  localparam int PORT_W     = 4;
  localparam int DATA_W     = 32;
  localparam int N_IN       = 4;
  localparam int CNT_W      = 4;
  localparam int DEST_W     = GROUP_W + LEAF_W;
  localparam int SRC_W      = $clog2(N_IN);
  localparam int EXP_W      = PORT_W + SRC_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN*DEST_W-1:0] in_dest;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [PORT_W-1:0]      out_port;
  logic [SRC_W-1:0]       out_src;
  logic [DATA_W-1:0]      out_data;
  logic                   route_err;
  logic [CNT_W-1:0]       drop_cnt;

  logic [DEST_W-1:0] dest_a [N_IN];
  logic [DATA_W-1:0] data_a [N_IN];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_pack
    assign in_dest[gi*DEST_W +: DEST_W] = dest_a[gi];
    assign in_data[gi*DATA_W +: DATA_W] = data_a[gi];
  end

  spine_route_arb_stage #(
    .GROUP_ID(GROUP_ID), .NUM_GROUPS(NUM_GROUPS), .NUM_LEAFS(NUM_LEAFS), .GROUP_W(GROUP_W),
    .LEAF_W(LEAF_W), .PORT_W(PORT_W), .DATA_W(DATA_W), .N_IN(N_IN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port), .out_src(out_src),
    .out_data(out_data), .route_err(route_err), .drop_cnt(drop_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (route_err) err_pulses++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=port%0d/src%0d/%0h expected=none", out_port, out_src,
                   out_data);
        end else begin
          check("out_item", 64'({out_port, out_src, out_data}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DATA_W-1:0] mk(input int i, input int k);
    return 32'hA000_0000 | DATA_W'(i << 8) | DATA_W'(k);
  endfunction

  task automatic send(input int i, input int g, input int l, input logic [DATA_W-1:0] d,
                      input int port, input bit push);
    bit got;
    if (push) exp_q.push_back({PORT_W'(port), SRC_W'(i), d});
    dest_a[i]   = {GROUP_W'(g), LEAF_W'(l)};
    data_a[i]   = d;
    in_valid[i] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (in_ready[i]) got = 1'b1;
    end
    check("send_accept", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic drain_inputs();
    logic [N_IN-1:0] r;
    for (int c = 0; c < 40 && in_valid != '0; c++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      in_valid = in_valid & ~r;
    end
    check("drain_inputs", 64'(in_valid), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_port"}, 64'(out_port), 64'd0);
    check({tag, "_out_src"}, 64'(out_src), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_route_err"}, 64'(route_err), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N_IN-1:0] r;
    int cnt [N_IN];
    int fport [N_IN];
    int total;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      dest_a[i] = '0;
      data_a[i] = '0;
    end
    #2;
    check_all_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_all_zero("post_reset");

    // Local leaf: {4,2} -> port 3, visible one cycle after accept.
    out_ready = 1'b1;
    send(0, 4, 2, 32'h1111_0001, 3, 1);
    check("local_latency", 64'(out_valid), 64'd1);

    // Remote groups 1,3,5,8 -> ports 5,7,8,11.
    send(1, 1, 0, 32'h2222_0001, 5, 1);
    send(1, 3, 1, 32'h2222_0003, 7, 1);
    send(1, 5, 2, 32'h2222_0005, 8, 1);
    send(1, 8, 3, 32'h2222_0008, 11, 1);
    idle(2);

    // Invalid groups 0 and 9 are consumed and dropped.
    err_pulses = 0;
    send(2, 0, 1, 32'h3333_0000, 0, 0);
    send(2, 9, 0, 32'h3333_0009, 0, 0);
    idle(2);
    check("invalid_drop_cnt", 64'(drop_cnt), 64'd2);
    check("invalid_err_pulses", 64'(err_pulses), 64'd2);
    check("invalid_out_valid", 64'(out_valid), 64'd0);

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Fairness: all inputs valid, two items each, grant order 0,1,2,3,0,1,2,3.
    fport = '{5, 6, 7, 4};
    dest_a[0] = {GROUP_W'(1), LEAF_W'(0)};
    dest_a[1] = {GROUP_W'(2), LEAF_W'(1)};
    dest_a[2] = {GROUP_W'(3), LEAF_W'(2)};
    dest_a[3] = {GROUP_W'(4), LEAF_W'(3)};
    for (int i = 0; i < N_IN; i++) begin
      data_a[i] = mk(i, 0);
      cnt[i] = 0;
    end
    for (int j = 0; j < 2 * N_IN; j++)
      exp_q.push_back({PORT_W'(fport[j % N_IN]), SRC_W'(j % N_IN), mk(j % N_IN, j / N_IN)});
    in_valid = '1;
    total = 0;
    for (int c = 0; c < 40 && total < 2 * N_IN; c++) begin
      @(negedge clk);
      r = in_ready;
      check("fair_one_per_cycle", 64'($countones(r)), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < N_IN; i++) begin
        if (r[i]) begin
          cnt[i]++;
          total++;
          if (cnt[i] == 2) in_valid[i] = 1'b0;
          else data_a[i] = mk(i, cnt[i]);
        end
      end
    end
    check("fair_total", 64'(total), 64'(2 * N_IN));
    idle(1);

    // Backpressure: hold item A for 5 cycles while B and C wait, then release.
    out_ready = 1'b0;
    send(0, 4, 1, 32'h4444_000A, 2, 1);
    exp_q.push_back({PORT_W'(9), SRC_W'(1), 32'h4444_000B});
    exp_q.push_back({PORT_W'(6), SRC_W'(2), 32'h4444_000C});
    dest_a[1] = {GROUP_W'(6), LEAF_W'(0)};
    data_a[1] = 32'h4444_000B;
    dest_a[2] = {GROUP_W'(2), LEAF_W'(3)};
    data_a[2] = 32'h4444_000C;
    in_valid[1] = 1'b1;
    in_valid[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_port", 64'(out_port), 64'd2);
      check("bp_out_src", 64'(out_src), 64'd0);
      check("bp_out_data", 64'(out_data), 64'h4444_000A);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain_inputs();
    idle(2);

    // Saturation: 20 drops on a 4-bit counter stop at 15.
    err_pulses = 0;
    for (int n = 0; n < 20; n++) send(3, 15, 0, DATA_W'(n), 0, 0);
    idle(2);
    check("sat_drop_cnt", 64'(drop_cnt), 64'd15);
    check("sat_err_pulses", 64'(err_pulses), 64'd20);

    // Reset mid-stream: held item discarded, outputs zero at once, arbitration back to input 0.
    out_ready = 1'b0;
    send(0, 4, 0, 32'h5555_0000, 1, 0);
    dest_a[1] = {GROUP_W'(2), LEAF_W'(0)};
    in_valid[1] = 1'b1;
    idle(1);
    rst_n = 1'b0;
    #2;
    check_all_zero("mid_reset");
    in_valid = '0;
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({PORT_W'(4), SRC_W'(0), 32'h6666_0000});
    exp_q.push_back({PORT_W'(11), SRC_W'(2), 32'h6666_0002});
    dest_a[0] = {GROUP_W'(4), LEAF_W'(3)};
    data_a[0] = 32'h6666_0000;
    dest_a[2] = {GROUP_W'(8), LEAF_W'(0)};
    data_a[2] = 32'h6666_0002;
    in_valid[0] = 1'b1;
    in_valid[2] = 1'b1;
    drain_inputs();
    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
